axi_amo_arb: RTL and testbench

//  2-master AXI4+ATOP arbiter sharing one axi_riscv_atomics slave port (e.g. core + DMA).

---
 rtl/axi_amo_arb_pkg.sv | 17 +
 rtl/axi_amo_arb_rr.sv | 52 +++++
 rtl/axi_amo_arb.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_axi_amo_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_amo_arb_pkg.sv
// Shared types for the two-master AXI4+ATOP arbiter in front of the atomics adapter.
// Master index, W route FIFO pointer/count types and the master count live here.
package axi_amo_arb_pkg;

  localparam int NUM_MST      = 2;
  localparam int W_FIFO_DEPTH = 4;

  typedef logic mst_idx_t;
  typedef logic [$clog2(W_FIFO_DEPTH)-1:0] w_ptr_t;
  typedef logic [$clog2(W_FIFO_DEPTH):0]   w_cnt_t;

  // Wrap at the configured depth so depths below the storage size still work.
  function automatic w_ptr_t w_ptr_inc(input w_ptr_t p, input int depth);
    return (int'(p) == depth - 1) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/axi_amo_arb_rr.sv
// Two-way round-robin arbiter with grant lock: once a grant is presented it is held
// until advance_i (the downstream handshake); prio_i requesters beat the others.
module axi_amo_arb_rr
  import axi_amo_arb_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_MST-1:0] req_i,
  input  logic [NUM_MST-1:0] prio_i,
  input  logic               advance_i,
  output mst_idx_t           gnt_o,
  output logic               gnt_valid_o
);

  mst_idx_t           ptr_q;
  mst_idx_t           lock_idx_q;
  logic               locked_q;
  logic [NUM_MST-1:0] cand;

  always_comb begin
    cand        = req_i;
    gnt_o       = ptr_q;
    gnt_valid_o = 1'b0;
    if ((req_i & prio_i) != '0) cand = req_i & prio_i;
    if (locked_q) begin
      gnt_o       = lock_idx_q;
      gnt_valid_o = req_i[lock_idx_q];
    end else if (cand == 2'b11) begin
      gnt_o       = ptr_q;
      gnt_valid_o = 1'b1;
    end else if (cand != '0) begin
      gnt_o       = cand[1];
      gnt_valid_o = 1'b1;
    end
  end

  // Pointer always moves past the winner, so a lone requester never starves the other.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= 1'b0;
      lock_idx_q <= 1'b0;
      locked_q   <= 1'b0;
    end else if (advance_i) begin
      locked_q <= 1'b0;
      ptr_q    <= ~gnt_o;
    end else if (gnt_valid_o) begin
      locked_q   <= 1'b1;
      lock_idx_q <= gnt_o;
    end
  end

endmodule

// File: rtl/axi_amo_arb.sv
// Two-master AXI4+ATOP arbiter feeding one axi_riscv_atomics slave port; ID widened by the
// master index. Optional macro AXI_AMO_ARB_ATOP_PRIO_EN lets atomic AWs beat plain AWs.
module axi_amo_arb
  import axi_amo_arb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_USER_WIDTH = 1,
  parameter int MAX_W_TXNS     = W_FIFO_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // master 0
  input  logic [AXI_ADDR_WIDTH-1:0]   s0_aw_addr_i,
  input  logic [2:0]                  s0_aw_prot_i,
  input  logic [3:0]                  s0_aw_region_i,
  input  logic [5:0]                  s0_aw_atop_i,
  input  logic [7:0]                  s0_aw_len_i,
  input  logic [2:0]                  s0_aw_size_i,
  input  logic [1:0]                  s0_aw_burst_i,
  input  logic                        s0_aw_lock_i,
  input  logic [3:0]                  s0_aw_cache_i,
  input  logic [3:0]                  s0_aw_qos_i,
  input  logic [AXI_ID_WIDTH-1:0]     s0_aw_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   s0_aw_user_i,
  input  logic                        s0_aw_valid_i,
  output logic                        s0_aw_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   s0_ar_addr_i,
  input  logic [2:0]                  s0_ar_prot_i,
  input  logic [3:0]                  s0_ar_region_i,
  input  logic [7:0]                  s0_ar_len_i,
  input  logic [2:0]                  s0_ar_size_i,
  input  logic [1:0]                  s0_ar_burst_i,
  input  logic                        s0_ar_lock_i,
  input  logic [3:0]                  s0_ar_cache_i,
  input  logic [3:0]                  s0_ar_qos_i,
  input  logic [AXI_ID_WIDTH-1:0]     s0_ar_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   s0_ar_user_i,
  input  logic                        s0_ar_valid_i,
  output logic                        s0_ar_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   s0_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] s0_w_strb_i,
  input  logic [AXI_USER_WIDTH-1:0]   s0_w_user_i,
  input  logic                        s0_w_last_i,
  input  logic                        s0_w_valid_i,
  output logic                        s0_w_ready_o,
  output logic [AXI_DATA_WIDTH-1:0]   s0_r_data_o,
  output logic [1:0]                  s0_r_resp_o,
  output logic                        s0_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]     s0_r_id_o,
  output logic [AXI_USER_WIDTH-1:0]   s0_r_user_o,
  output logic                        s0_r_valid_o,
  input  logic                        s0_r_ready_i,
  output logic [1:0]                  s0_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]     s0_b_id_o,
  output logic [AXI_USER_WIDTH-1:0]   s0_b_user_o,
  output logic                        s0_b_valid_o,
  input  logic                        s0_b_ready_i,
  // master 1
  input  logic [AXI_ADDR_WIDTH-1:0]   s1_aw_addr_i,
  input  logic [2:0]                  s1_aw_prot_i,
  input  logic [3:0]                  s1_aw_region_i,
  input  logic [5:0]                  s1_aw_atop_i,
  input  logic [7:0]                  s1_aw_len_i,
  input  logic [2:0]                  s1_aw_size_i,
  input  logic [1:0]                  s1_aw_burst_i,
  input  logic                        s1_aw_lock_i,
  input  logic [3:0]                  s1_aw_cache_i,
  input  logic [3:0]                  s1_aw_qos_i,
  input  logic [AXI_ID_WIDTH-1:0]     s1_aw_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   s1_aw_user_i,
  input  logic                        s1_aw_valid_i,
  output logic                        s1_aw_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   s1_ar_addr_i,
  input  logic [2:0]                  s1_ar_prot_i,
  input  logic [3:0]                  s1_ar_region_i,
  input  logic [7:0]                  s1_ar_len_i,
  input  logic [2:0]                  s1_ar_size_i,
  input  logic [1:0]                  s1_ar_burst_i,
  input  logic                        s1_ar_lock_i,
  input  logic [3:0]                  s1_ar_cache_i,
  input  logic [3:0]                  s1_ar_qos_i,
  input  logic [AXI_ID_WIDTH-1:0]     s1_ar_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   s1_ar_user_i,
  input  logic                        s1_ar_valid_i,
  output logic                        s1_ar_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   s1_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] s1_w_strb_i,
  input  logic [AXI_USER_WIDTH-1:0]   s1_w_user_i,
  input  logic                        s1_w_last_i,
  input  logic                        s1_w_valid_i,
  output logic                        s1_w_ready_o,
  output logic [AXI_DATA_WIDTH-1:0]   s1_r_data_o,
  output logic [1:0]                  s1_r_resp_o,
  output logic                        s1_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]     s1_r_id_o,
  output logic [AXI_USER_WIDTH-1:0]   s1_r_user_o,
  output logic                        s1_r_valid_o,
  input  logic                        s1_r_ready_i,
  output logic [1:0]                  s1_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]     s1_b_id_o,
  output logic [AXI_USER_WIDTH-1:0]   s1_b_user_o,
  output logic                        s1_b_valid_o,
  input  logic                        s1_b_ready_i,
  // downstream (atomics adapter slave port)
  output logic [AXI_ADDR_WIDTH-1:0]   m_aw_addr_o,
  output logic [2:0]                  m_aw_prot_o,
  output logic [3:0]                  m_aw_region_o,
  output logic [5:0]                  m_aw_atop_o,
  output logic [7:0]                  m_aw_len_o,
  output logic [2:0]                  m_aw_size_o,
  output logic [1:0]                  m_aw_burst_o,
  output logic                        m_aw_lock_o,
  output logic [3:0]                  m_aw_cache_o,
  output logic [3:0]                  m_aw_qos_o,
  output logic [AXI_ID_WIDTH:0]       m_aw_id_o,
  output logic [AXI_USER_WIDTH-1:0]   m_aw_user_o,
  output logic                        m_aw_valid_o,
  input  logic                        m_aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   m_ar_addr_o,
  output logic [2:0]                  m_ar_prot_o,
  output logic [3:0]                  m_ar_region_o,
  output logic [7:0]                  m_ar_len_o,
  output logic [2:0]                  m_ar_size_o,
  output logic [1:0]                  m_ar_burst_o,
  output logic                        m_ar_lock_o,
  output logic [3:0]                  m_ar_cache_o,
  output logic [3:0]                  m_ar_qos_o,
  output logic [AXI_ID_WIDTH:0]       m_ar_id_o,
  output logic [AXI_USER_WIDTH-1:0]   m_ar_user_o,
  output logic                        m_ar_valid_o,
  input  logic                        m_ar_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   m_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] m_w_strb_o,
  output logic [AXI_USER_WIDTH-1:0]   m_w_user_o,
  output logic                        m_w_last_o,
  output logic                        m_w_valid_o,
  input  logic                        m_w_ready_i,
  input  logic [AXI_DATA_WIDTH-1:0]   m_r_data_i,
  input  logic [1:0]                  m_r_resp_i,
  input  logic                        m_r_last_i,
  input  logic [AXI_ID_WIDTH:0]       m_r_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   m_r_user_i,
  input  logic                        m_r_valid_i,
  output logic                        m_r_ready_o,
  input  logic [1:0]                  m_b_resp_i,
  input  logic [AXI_ID_WIDTH:0]       m_b_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   m_b_user_i,
  input  logic                        m_b_valid_i,
  output logic                        m_b_ready_o
);

  mst_idx_t           aw_gnt, ar_gnt, w_head;
  logic               aw_gnt_valid, ar_gnt_valid, aw_hs, ar_hs;
  logic [NUM_MST-1:0] aw_req, aw_prio, ar_req;
  logic               w_full, w_empty, w_push, w_pop;
  w_ptr_t             w_wr_q, w_rd_q;
  w_cnt_t             w_cnt_q;
  mst_idx_t           w_fifo_q [MAX_W_TXNS];

  // ---------------- AW: round-robin, blocked while the W route FIFO is full
  assign w_full = (w_cnt_q == w_cnt_t'(MAX_W_TXNS));
  assign aw_req = {s1_aw_valid_i, s0_aw_valid_i} & {NUM_MST{~w_full}};
`ifdef AXI_AMO_ARB_ATOP_PRIO_EN
  assign aw_prio = {(s1_aw_atop_i != 6'd0), (s0_aw_atop_i != 6'd0)};
`else
  assign aw_prio = '0;
`endif

  axi_amo_arb_rr u_aw_rr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (aw_req),
    .prio_i      (aw_prio),
    .advance_i   (aw_hs),
    .gnt_o       (aw_gnt),
    .gnt_valid_o (aw_gnt_valid)
  );

  assign m_aw_valid_o  = aw_gnt_valid;
  assign aw_hs         = aw_gnt_valid & m_aw_ready_i;
  assign s0_aw_ready_o = aw_hs & ~aw_gnt;
  assign s1_aw_ready_o = aw_hs & aw_gnt;

  assign m_aw_addr_o   = aw_gnt ? s1_aw_addr_i   : s0_aw_addr_i;
  assign m_aw_prot_o   = aw_gnt ? s1_aw_prot_i   : s0_aw_prot_i;
  assign m_aw_region_o = aw_gnt ? s1_aw_region_i : s0_aw_region_i;
  assign m_aw_atop_o   = aw_gnt ? s1_aw_atop_i   : s0_aw_atop_i;
  assign m_aw_len_o    = aw_gnt ? s1_aw_len_i    : s0_aw_len_i;
  assign m_aw_size_o   = aw_gnt ? s1_aw_size_i   : s0_aw_size_i;
  assign m_aw_burst_o  = aw_gnt ? s1_aw_burst_i  : s0_aw_burst_i;
  assign m_aw_lock_o   = aw_gnt ? s1_aw_lock_i   : s0_aw_lock_i;
  assign m_aw_cache_o  = aw_gnt ? s1_aw_cache_i  : s0_aw_cache_i;
  assign m_aw_qos_o    = aw_gnt ? s1_aw_qos_i    : s0_aw_qos_i;
  assign m_aw_user_o   = aw_gnt ? s1_aw_user_i   : s0_aw_user_i;
  assign m_aw_id_o     = {aw_gnt, (aw_gnt ? s1_aw_id_i : s0_aw_id_i)};

  // ---------------- AR: same arbitration, no ordering state needed
  assign ar_req = {s1_ar_valid_i, s0_ar_valid_i};

  axi_amo_arb_rr u_ar_rr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (ar_req),
    .prio_i      ('0),
    .advance_i   (ar_hs),
    .gnt_o       (ar_gnt),
    .gnt_valid_o (ar_gnt_valid)
  );

  assign m_ar_valid_o  = ar_gnt_valid;
  assign ar_hs         = ar_gnt_valid & m_ar_ready_i;
  assign s0_ar_ready_o = ar_hs & ~ar_gnt;
  assign s1_ar_ready_o = ar_hs & ar_gnt;

  assign m_ar_addr_o   = ar_gnt ? s1_ar_addr_i   : s0_ar_addr_i;
  assign m_ar_prot_o   = ar_gnt ? s1_ar_prot_i   : s0_ar_prot_i;
  assign m_ar_region_o = ar_gnt ? s1_ar_region_i : s0_ar_region_i;
  assign m_ar_len_o    = ar_gnt ? s1_ar_len_i    : s0_ar_len_i;
  assign m_ar_size_o   = ar_gnt ? s1_ar_size_i   : s0_ar_size_i;
  assign m_ar_burst_o  = ar_gnt ? s1_ar_burst_i  : s0_ar_burst_i;
  assign m_ar_lock_o   = ar_gnt ? s1_ar_lock_i   : s0_ar_lock_i;
  assign m_ar_cache_o  = ar_gnt ? s1_ar_cache_i  : s0_ar_cache_i;
  assign m_ar_qos_o    = ar_gnt ? s1_ar_qos_i    : s0_ar_qos_i;
  assign m_ar_user_o   = ar_gnt ? s1_ar_user_i   : s0_ar_user_i;
  assign m_ar_id_o     = {ar_gnt, (ar_gnt ? s1_ar_id_i : s0_ar_id_i)};

  // ---------------- W route FIFO: one entry per accepted AW, popped on the last beat.
  // Emptiness is registered, so a W beat never overtakes its own AW in the same cycle.
  assign w_push  = aw_hs;
  assign w_empty = (w_cnt_q == '0);
  assign w_head  = w_fifo_q[w_rd_q];
  assign w_pop   = m_w_valid_o & m_w_ready_i & m_w_last_o;

  always_ff @(posedge clk_i) begin
    if (w_push) w_fifo_q[w_wr_q] <= aw_gnt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_wr_q  <= '0;
      w_rd_q  <= '0;
      w_cnt_q <= '0;
    end else begin
      if (w_push) w_wr_q <= w_ptr_inc(w_wr_q, MAX_W_TXNS);
      if (w_pop)  w_rd_q <= w_ptr_inc(w_rd_q, MAX_W_TXNS);
      case ({w_push, w_pop})
        2'b10:   w_cnt_q <= w_cnt_q + 1'b1;
        2'b01:   w_cnt_q <= w_cnt_q - 1'b1;
        default: w_cnt_q <= w_cnt_q;
      endcase
    end
  end

  assign m_w_valid_o  = ~w_empty & (w_head ? s1_w_valid_i : s0_w_valid_i);
  assign m_w_data_o   = w_head ? s1_w_data_i : s0_w_data_i;
  assign m_w_strb_o   = w_head ? s1_w_strb_i : s0_w_strb_i;
  assign m_w_user_o   = w_head ? s1_w_user_i : s0_w_user_i;
  assign m_w_last_o   = w_head ? s1_w_last_i : s0_w_last_i;
  assign s0_w_ready_o = ~w_empty & ~w_head & m_w_ready_i;
  assign s1_w_ready_o = ~w_empty & w_head & m_w_ready_i;

  // ---------------- R/B: route on the ID MSB, strip it on the way back
  assign s0_r_valid_o = m_r_valid_i & ~m_r_id_i[AXI_ID_WIDTH];
  assign s1_r_valid_o = m_r_valid_i & m_r_id_i[AXI_ID_WIDTH];
  assign m_r_ready_o  = m_r_id_i[AXI_ID_WIDTH] ? s1_r_ready_i : s0_r_ready_i;
  assign s0_r_data_o  = m_r_data_i;
  assign s1_r_data_o  = m_r_data_i;
  assign s0_r_resp_o  = m_r_resp_i;
  assign s1_r_resp_o  = m_r_resp_i;
  assign s0_r_last_o  = m_r_last_i;
  assign s1_r_last_o  = m_r_last_i;
  assign s0_r_id_o    = m_r_id_i[AXI_ID_WIDTH-1:0];
  assign s1_r_id_o    = m_r_id_i[AXI_ID_WIDTH-1:0];
  assign s0_r_user_o  = m_r_user_i;
  assign s1_r_user_o  = m_r_user_i;

  assign s0_b_valid_o = m_b_valid_i & ~m_b_id_i[AXI_ID_WIDTH];
  assign s1_b_valid_o = m_b_valid_i & m_b_id_i[AXI_ID_WIDTH];
  assign m_b_ready_o  = m_b_id_i[AXI_ID_WIDTH] ? s1_b_ready_i : s0_b_ready_i;
  assign s0_b_resp_o  = m_b_resp_i;
  assign s1_b_resp_o  = m_b_resp_i;
  assign s0_b_id_o    = m_b_id_i[AXI_ID_WIDTH-1:0];
  assign s1_b_id_o    = m_b_id_i[AXI_ID_WIDTH-1:0];
  assign s0_b_user_o  = m_b_user_i;
  assign s1_b_user_o  = m_b_user_i;

endmodule

// File: tb/tb_axi_amo_arb.sv
// Directed bench for axi_amo_arb: arbitration, grant lock, W routing, FIFO-full
// back-pressure, R/B return routing and the optional atomic-priority build.
module tb_axi_amo_arb;

  localparam int AW = 64, DW = 64, IW = 10, UW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // upstream bundles, index = master
  logic [AW-1:0]   s_aw_addr [2], s_ar_addr [2];
  logic [2:0]      s_aw_prot [2], s_ar_prot [2], s_aw_size [2], s_ar_size [2];
  logic [3:0]      s_aw_region [2], s_ar_region [2], s_aw_cache [2], s_ar_cache [2];
  logic [3:0]      s_aw_qos [2], s_ar_qos [2];
  logic [5:0]      s_aw_atop [2];
  logic [7:0]      s_aw_len [2], s_ar_len [2];
  logic [1:0]      s_aw_burst [2], s_ar_burst [2];
  logic            s_aw_lock [2], s_ar_lock [2];
  logic [IW-1:0]   s_aw_id [2], s_ar_id [2];
  logic [UW-1:0]   s_aw_user [2], s_ar_user [2], s_w_user [2];
  logic            s_aw_valid [2], s_aw_ready [2], s_ar_valid [2], s_ar_ready [2];
  logic [DW-1:0]   s_w_data [2];
  logic [DW/8-1:0] s_w_strb [2];
  logic            s_w_last [2], s_w_valid [2], s_w_ready [2];
  logic [DW-1:0]   s_r_data [2];
  logic [1:0]      s_r_resp [2], s_b_resp [2];
  logic            s_r_last [2], s_r_valid [2], s_r_ready [2];
  logic [IW-1:0]   s_r_id [2], s_b_id [2];
  logic [UW-1:0]   s_r_user [2], s_b_user [2];
  logic            s_b_valid [2], s_b_ready [2];

  // downstream
  logic [AW-1:0]   m_aw_addr, m_ar_addr;
  logic [2:0]      m_aw_prot, m_ar_prot, m_aw_size, m_ar_size;
  logic [3:0]      m_aw_region, m_ar_region, m_aw_cache, m_ar_cache, m_aw_qos, m_ar_qos;
  logic [5:0]      m_aw_atop;
  logic [7:0]      m_aw_len, m_ar_len;
  logic [1:0]      m_aw_burst, m_ar_burst;
  logic            m_aw_lock, m_ar_lock;
  logic [IW:0]     m_aw_id, m_ar_id, m_r_id, m_b_id;
  logic [UW-1:0]   m_aw_user, m_ar_user, m_w_user, m_r_user, m_b_user;
  logic            m_aw_valid, m_aw_ready, m_ar_valid, m_ar_ready;
  logic [DW-1:0]   m_w_data, m_r_data;
  logic [DW/8-1:0] m_w_strb;
  logic            m_w_last, m_w_valid, m_w_ready;
  logic [1:0]      m_r_resp, m_b_resp;
  logic            m_r_last, m_r_valid, m_r_ready, m_b_valid, m_b_ready;

  axi_amo_arb dut (
    .clk_i(clk), .rst_i(rst),
    .s0_aw_addr_i(s_aw_addr[0]), .s0_aw_prot_i(s_aw_prot[0]), .s0_aw_region_i(s_aw_region[0]),
    .s0_aw_atop_i(s_aw_atop[0]), .s0_aw_len_i(s_aw_len[0]), .s0_aw_size_i(s_aw_size[0]),
    .s0_aw_burst_i(s_aw_burst[0]), .s0_aw_lock_i(s_aw_lock[0]), .s0_aw_cache_i(s_aw_cache[0]),
    .s0_aw_qos_i(s_aw_qos[0]), .s0_aw_id_i(s_aw_id[0]), .s0_aw_user_i(s_aw_user[0]),
    .s0_aw_valid_i(s_aw_valid[0]), .s0_aw_ready_o(s_aw_ready[0]),
    .s0_ar_addr_i(s_ar_addr[0]), .s0_ar_prot_i(s_ar_prot[0]), .s0_ar_region_i(s_ar_region[0]),
    .s0_ar_len_i(s_ar_len[0]), .s0_ar_size_i(s_ar_size[0]), .s0_ar_burst_i(s_ar_burst[0]),
    .s0_ar_lock_i(s_ar_lock[0]), .s0_ar_cache_i(s_ar_cache[0]), .s0_ar_qos_i(s_ar_qos[0]),
    .s0_ar_id_i(s_ar_id[0]), .s0_ar_user_i(s_ar_user[0]),
    .s0_ar_valid_i(s_ar_valid[0]), .s0_ar_ready_o(s_ar_ready[0]),
    .s0_w_data_i(s_w_data[0]), .s0_w_strb_i(s_w_strb[0]), .s0_w_user_i(s_w_user[0]),
    .s0_w_last_i(s_w_last[0]), .s0_w_valid_i(s_w_valid[0]), .s0_w_ready_o(s_w_ready[0]),
    .s0_r_data_o(s_r_data[0]), .s0_r_resp_o(s_r_resp[0]), .s0_r_last_o(s_r_last[0]),
    .s0_r_id_o(s_r_id[0]), .s0_r_user_o(s_r_user[0]), .s0_r_valid_o(s_r_valid[0]),
    .s0_r_ready_i(s_r_ready[0]),
    .s0_b_resp_o(s_b_resp[0]), .s0_b_id_o(s_b_id[0]), .s0_b_user_o(s_b_user[0]),
    .s0_b_valid_o(s_b_valid[0]), .s0_b_ready_i(s_b_ready[0]),
    .s1_aw_addr_i(s_aw_addr[1]), .s1_aw_prot_i(s_aw_prot[1]), .s1_aw_region_i(s_aw_region[1]),
    .s1_aw_atop_i(s_aw_atop[1]), .s1_aw_len_i(s_aw_len[1]), .s1_aw_size_i(s_aw_size[1]),
    .s1_aw_burst_i(s_aw_burst[1]), .s1_aw_lock_i(s_aw_lock[1]), .s1_aw_cache_i(s_aw_cache[1]),
    .s1_aw_qos_i(s_aw_qos[1]), .s1_aw_id_i(s_aw_id[1]), .s1_aw_user_i(s_aw_user[1]),
    .s1_aw_valid_i(s_aw_valid[1]), .s1_aw_ready_o(s_aw_ready[1]),
    .s1_ar_addr_i(s_ar_addr[1]), .s1_ar_prot_i(s_ar_prot[1]), .s1_ar_region_i(s_ar_region[1]),
    .s1_ar_len_i(s_ar_len[1]), .s1_ar_size_i(s_ar_size[1]), .s1_ar_burst_i(s_ar_burst[1]),
    .s1_ar_lock_i(s_ar_lock[1]), .s1_ar_cache_i(s_ar_cache[1]), .s1_ar_qos_i(s_ar_qos[1]),
    .s1_ar_id_i(s_ar_id[1]), .s1_ar_user_i(s_ar_user[1]),
    .s1_ar_valid_i(s_ar_valid[1]), .s1_ar_ready_o(s_ar_ready[1]),
    .s1_w_data_i(s_w_data[1]), .s1_w_strb_i(s_w_strb[1]), .s1_w_user_i(s_w_user[1]),
    .s1_w_last_i(s_w_last[1]), .s1_w_valid_i(s_w_valid[1]), .s1_w_ready_o(s_w_ready[1]),
    .s1_r_data_o(s_r_data[1]), .s1_r_resp_o(s_r_resp[1]), .s1_r_last_o(s_r_last[1]),
    .s1_r_id_o(s_r_id[1]), .s1_r_user_o(s_r_user[1]), .s1_r_valid_o(s_r_valid[1]),
    .s1_r_ready_i(s_r_ready[1]),
    .s1_b_resp_o(s_b_resp[1]), .s1_b_id_o(s_b_id[1]), .s1_b_user_o(s_b_user[1]),
    .s1_b_valid_o(s_b_valid[1]), .s1_b_ready_i(s_b_ready[1]),
    .m_aw_addr_o(m_aw_addr), .m_aw_prot_o(m_aw_prot), .m_aw_region_o(m_aw_region),
    .m_aw_atop_o(m_aw_atop), .m_aw_len_o(m_aw_len), .m_aw_size_o(m_aw_size),
    .m_aw_burst_o(m_aw_burst), .m_aw_lock_o(m_aw_lock), .m_aw_cache_o(m_aw_cache),
    .m_aw_qos_o(m_aw_qos), .m_aw_id_o(m_aw_id), .m_aw_user_o(m_aw_user),
    .m_aw_valid_o(m_aw_valid), .m_aw_ready_i(m_aw_ready),
    .m_ar_addr_o(m_ar_addr), .m_ar_prot_o(m_ar_prot), .m_ar_region_o(m_ar_region),
    .m_ar_len_o(m_ar_len), .m_ar_size_o(m_ar_size), .m_ar_burst_o(m_ar_burst),
    .m_ar_lock_o(m_ar_lock), .m_ar_cache_o(m_ar_cache), .m_ar_qos_o(m_ar_qos),
    .m_ar_id_o(m_ar_id), .m_ar_user_o(m_ar_user),
    .m_ar_valid_o(m_ar_valid), .m_ar_ready_i(m_ar_ready),
    .m_w_data_o(m_w_data), .m_w_strb_o(m_w_strb), .m_w_user_o(m_w_user),
    .m_w_last_o(m_w_last), .m_w_valid_o(m_w_valid), .m_w_ready_i(m_w_ready),
    .m_r_data_i(m_r_data), .m_r_resp_i(m_r_resp), .m_r_last_i(m_r_last),
    .m_r_id_i(m_r_id), .m_r_user_i(m_r_user), .m_r_valid_i(m_r_valid), .m_r_ready_o(m_r_ready),
    .m_b_resp_i(m_b_resp), .m_b_id_i(m_b_id), .m_b_user_i(m_b_user),
    .m_b_valid_i(m_b_valid), .m_b_ready_o(m_b_ready)
  );

  // ---------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];   // expected W route order (master index per accepted AW)

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_all();
    for (int m = 0; m < 2; m++) begin
      s_aw_addr[m] = '0; s_aw_prot[m] = '0; s_aw_region[m] = '0; s_aw_atop[m] = '0;
      s_aw_len[m] = '0; s_aw_size[m] = 3'd3; s_aw_burst[m] = 2'd1; s_aw_lock[m] = 1'b0;
      s_aw_cache[m] = '0; s_aw_qos[m] = '0; s_aw_id[m] = '0; s_aw_user[m] = '0;
      s_aw_valid[m] = 1'b0;
      s_ar_addr[m] = '0; s_ar_prot[m] = '0; s_ar_region[m] = '0; s_ar_len[m] = '0;
      s_ar_size[m] = 3'd3; s_ar_burst[m] = 2'd1; s_ar_lock[m] = 1'b0; s_ar_cache[m] = '0;
      s_ar_qos[m] = '0; s_ar_id[m] = '0; s_ar_user[m] = '0; s_ar_valid[m] = 1'b0;
      s_w_data[m] = '0; s_w_strb[m] = '1; s_w_user[m] = '0; s_w_last[m] = 1'b0;
      s_w_valid[m] = 1'b0; s_r_ready[m] = 1'b0; s_b_ready[m] = 1'b0;
    end
    m_aw_ready = 1'b1; m_ar_ready = 1'b1; m_w_ready = 1'b1;
    m_r_data = '0; m_r_resp = '0; m_r_last = 1'b0; m_r_id = '0; m_r_user = '0; m_r_valid = 1'b0;
    m_b_resp = '0; m_b_id = '0; m_b_user = '0; m_b_valid = 1'b0;
  endtask

  task automatic aw_drive(input int m, input logic v, input logic [63:0] addr,
                          input logic [IW-1:0] id, input logic [7:0] len, input logic [5:0] atop);
    s_aw_valid[m] = v; s_aw_addr[m] = addr; s_aw_id[m] = id;
    s_aw_len[m] = len; s_aw_atop[m] = atop;
  endtask

  task automatic w_drive(input int m, input logic v, input logic [63:0] data, input logic last);
    s_w_valid[m] = v; s_w_data[m] = data; s_w_last[m] = last;
  endtask

  // One single-beat W per queued entry; both masters offer data so misrouting shows.
  task automatic drain_w();
    logic [0:0] idx;
    int k;
    k = 0;
    m_w_ready = 1'b1;
    while (exp_q.size() > 0) begin
      idx = exp_q.pop_front();
      w_drive(0, 1'b1, 64'hD000 + 64'(k * 2), 1'b1);
      w_drive(1, 1'b1, 64'hD001 + 64'(k * 2), 1'b1);
      settle();
      check("w_route_data", m_w_data, (idx == 1'b1) ? 64'hD001 + 64'(k * 2) : 64'hD000 + 64'(k * 2));
      check("w_route_rdy_sel", {63'd0, s_w_ready[idx]}, 64'd1);
      check("w_route_rdy_oth", {63'd0, s_w_ready[~idx]}, 64'd0);
      step();
      k++;
    end
    w_drive(0, 1'b0, '0, 1'b0);
    w_drive(1, 1'b0, '0, 1'b0);
    settle();
    check("w_empty_valid", {63'd0, m_w_valid}, 64'd0);
  endtask

  logic [0:0] prio_win;

  initial begin
    idle_all();
    // ---------------- reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_m_aw_valid", {63'd0, m_aw_valid}, 64'd0);
    check("rst_m_w_valid", {63'd0, m_w_valid}, 64'd0);
    check("rst_s0_w_ready", {63'd0, s_w_ready[0]}, 64'd0);
    check("rst_s1_aw_ready", {63'd0, s_aw_ready[1]}, 64'd0);
    rst = 1'b0;
    step();
    check("post_rst_m_ar_valid", {63'd0, m_ar_valid}, 64'd0);

    // ---------------- both AW/AR valid, pointer at master 0
    aw_drive(0, 1'b1, 64'h1000, 10'h011, 8'd0, 6'd0);
    aw_drive(1, 1'b1, 64'h1800, 10'h022, 8'd0, 6'd0);
    s_ar_valid[0] = 1'b1; s_ar_id[0] = 10'h055;
    s_ar_valid[1] = 1'b1; s_ar_id[1] = 10'h066;
    settle();
    check("rr_aw_first_id", 64'(m_aw_id), 64'h011);
    check("rr_aw_first_addr", m_aw_addr, 64'h1000);
    check("rr_aw_s0_ready", {63'd0, s_aw_ready[0]}, 64'd1);
    check("rr_aw_s1_ready", {63'd0, s_aw_ready[1]}, 64'd0);
    check("rr_ar_first_id", 64'(m_ar_id), 64'h055);
    step(); exp_q.push_back(1'b0);
    check("rr_aw_second_id", 64'(m_aw_id), 64'h422);
    check("rr_aw_second_s1_ready", {63'd0, s_aw_ready[1]}, 64'd1);
    check("rr_ar_second_id", 64'(m_ar_id), 64'h466);
    step(); exp_q.push_back(1'b1);
    aw_drive(0, 1'b0, '0, '0, 8'd0, 6'd0);
    aw_drive(1, 1'b0, '0, '0, 8'd0, 6'd0);
    s_ar_valid[0] = 1'b0; s_ar_valid[1] = 1'b0;
    drain_w();

    // ---------------- grant lock while downstream stalls (pointer first moved to master 1)
    aw_drive(0, 1'b1, 64'h0F00, 10'h001, 8'd0, 6'd0);
    step(); exp_q.push_back(1'b0);
    m_aw_ready = 1'b0;
    aw_drive(0, 1'b1, 64'h2000, 10'h033, 8'd0, 6'd0);
    settle();
    check("lock_m_aw_valid", {63'd0, m_aw_valid}, 64'd1);
    check("lock_s0_ready_stall", {63'd0, s_aw_ready[0]}, 64'd0);
    step();
    aw_drive(1, 1'b1, 64'h3000, 10'h044, 8'd0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("lock_hold_id", 64'(m_aw_id), 64'h033);
      check("lock_hold_addr", m_aw_addr, 64'h2000);
      step();
    end
    m_aw_ready = 1'b1;
    settle();
    check("lock_release_s0", {63'd0, s_aw_ready[0]}, 64'd1);
    check("lock_release_s1", {63'd0, s_aw_ready[1]}, 64'd0);
    step(); exp_q.push_back(1'b0);
    aw_drive(0, 1'b0, '0, '0, 8'd0, 6'd0);
    settle();
    check("lock_next_id", 64'(m_aw_id), 64'h444);
    step(); exp_q.push_back(1'b1);
    aw_drive(1, 1'b0, '0, '0, 8'd0, 6'd0);
    drain_w();

    // ---------------- burst ordering: m0 len=3 then m1 len=0; W offered with its AW
    aw_drive(0, 1'b1, 64'h4000, 10'h010, 8'd3, 6'd0);
    w_drive(0, 1'b1, 64'hA0, 1'b0);
    settle();
    check("wfwd_same_cycle_valid", {63'd0, m_w_valid}, 64'd0);
    check("wfwd_same_cycle_ready", {63'd0, s_w_ready[0]}, 64'd0);
    check("burst_aw_len", 64'(m_aw_len), 64'd3);
    step();
    aw_drive(0, 1'b0, '0, '0, 8'd0, 6'd0);
    aw_drive(1, 1'b1, 64'h5000, 10'h020, 8'd0, 6'd0);
    w_drive(1, 1'b1, 64'hBB, 1'b1);
    for (int k = 0; k < 4; k++) begin
      w_drive(0, 1'b1, 64'hA0 + 64'(k), (k == 3));
      settle();
      if (k == 0) check("burst_aw1_id", 64'(m_aw_id), 64'h420);
      check("burst_m0_data", m_w_data, 64'hA0 + 64'(k));
      check("burst_m0_last", {63'd0, m_w_last}, (k == 3) ? 64'd1 : 64'd0);
      check("burst_s1_wready", {63'd0, s_w_ready[1]}, 64'd0);
      step();
      if (k == 0) aw_drive(1, 1'b0, '0, '0, 8'd0, 6'd0);
    end
    w_drive(0, 1'b0, '0, 1'b0);
    settle();
    check("burst_m1_data", m_w_data, 64'hBB);
    check("burst_m1_wready", {63'd0, s_w_ready[1]}, 64'd1);
    step();
    w_drive(1, 1'b0, '0, 1'b0);
    settle();
    check("burst_done_valid", {63'd0, m_w_valid}, 64'd0);

    // ---------------- FIFO full: 4 AWs without W, 5th waits for a wlast handshake
    m_w_ready = 1'b0;
    aw_drive(0, 1'b1, 64'h6000, 10'h060, 8'd0, 6'd0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("full_fill_ready", {63'd0, s_aw_ready[0]}, 64'd1);
      step(); exp_q.push_back(1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      settle();
      check("full_block_ready", {63'd0, s_aw_ready[0]}, 64'd0);
      check("full_block_valid", {63'd0, m_aw_valid}, 64'd0);
      step();
    end
    m_w_ready = 1'b1;
    w_drive(0, 1'b1, 64'hC0, 1'b1);
    settle();
    check("full_pop_wvalid", {63'd0, m_w_valid}, 64'd1);
    check("full_pop_cycle_block", {63'd0, s_aw_ready[0]}, 64'd0);
    step(); void'(exp_q.pop_front());
    w_drive(0, 1'b0, '0, 1'b0);
    settle();
    check("full_freed_ready", {63'd0, s_aw_ready[0]}, 64'd1);
    step(); exp_q.push_back(1'b0);
    aw_drive(0, 1'b0, '0, '0, 8'd0, 6'd0);
    drain_w();

    // ---------------- R/B return routing
    m_b_valid = 1'b1; m_b_id = {1'b1, 10'h2A}; s_b_ready[1] = 1'b1; s_b_ready[0] = 1'b0;
    m_r_valid = 1'b1; m_r_id = {1'b1, 10'h2A}; m_r_data = 64'hFEED_0001; m_r_last = 1'b1;
    s_r_ready[1] = 1'b1; s_r_ready[0] = 1'b0;
    settle();
    check("b1_valid", {63'd0, s_b_valid[1]}, 64'd1);
    check("b1_id", 64'(s_b_id[1]), 64'h2A);
    check("b0_valid", {63'd0, s_b_valid[0]}, 64'd0);
    check("b1_mready", {63'd0, m_b_ready}, 64'd1);
    check("r1_valid", {63'd0, s_r_valid[1]}, 64'd1);
    check("r1_id", 64'(s_r_id[1]), 64'h2A);
    check("r1_data", s_r_data[1], 64'hFEED_0001);
    check("r0_valid", {63'd0, s_r_valid[0]}, 64'd0);
    step();
    m_b_id = {1'b0, 10'h15}; m_r_id = {1'b0, 10'h15};
    settle();
    check("b0_sel_valid", {63'd0, s_b_valid[0]}, 64'd1);
    check("b0_sel_id", 64'(s_b_id[0]), 64'h15);
    check("b0_sel_other", {63'd0, s_b_valid[1]}, 64'd0);
    check("b0_sel_mready", {63'd0, m_b_ready}, 64'd0);
    check("r0_sel_valid", {63'd0, s_r_valid[0]}, 64'd1);
    check("r0_sel_mready", {63'd0, m_r_ready}, 64'd0);
    step();
    m_b_valid = 1'b0; m_r_valid = 1'b0;

    // ---------------- atomic priority (pointer first moved back to master 0)
    aw_drive(1, 1'b1, 64'h7000, 10'h070, 8'd0, 6'd0);
    step(); exp_q.push_back(1'b1);
`ifdef AXI_AMO_ARB_ATOP_PRIO_EN
    prio_win = 1'b1;
`else
    prio_win = 1'b0;
`endif
    aw_drive(0, 1'b1, 64'h8000, 10'h001, 8'd0, 6'd0);
    aw_drive(1, 1'b1, 64'h9000, 10'h002, 8'd0, 6'h20);
    settle();
    check("prio_winner_id", 64'(m_aw_id), (prio_win == 1'b1) ? 64'h402 : 64'h001);
    step(); exp_q.push_back(prio_win);
    aw_drive(int'(prio_win), 1'b0, '0, '0, 8'd0, 6'd0);
    settle();
    check("prio_loser_id", 64'(m_aw_id), (prio_win == 1'b1) ? 64'h001 : 64'h402);
    step(); exp_q.push_back(~prio_win);
    aw_drive(0, 1'b0, '0, '0, 8'd0, 6'd0);
    aw_drive(1, 1'b0, '0, '0, 8'd0, 6'd0);
    drain_w();

    // ---------------- final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
